// File: rtl/mem_bus_responder.sv
// Word-wide load/store bus responder: fixed wait states, one-cycle ACK,
// byte-masked scratch RAM and complementary return-data driver enables.
module mem_bus_responder #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned WAIT   = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [3:0]        BE,
    input  logic [31:0]       WDATA,
    output logic [31:0]       RDATA,
    output logic              ACK,
    output logic              BUS_OE,
    output logic              nBUS_OE
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_C = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;

    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;

    logic [31:0]         mem_q [DEPTH];

    logic [31:0]         rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                oe_q, oe_d;

    logic                latch;
    logic                complete;

    logic                cur_we;
    logic [ADDR_W-1:0]   cur_addr;
    logic [3:0]          cur_be;
    logic [31:0]         cur_wdata;

    // With no wait states the request completes on its accept edge, before
    // the latched copy exists, so the live inputs are used in IDLE.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = WE;
            cur_addr  = ADDR;
            cur_be    = BE;
            cur_wdata = WDATA;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_be    = be_q;
            cur_wdata = wdata_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch    = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (REQ) begin
                    latch = 1'b1;
                    if (WAIT_C == 4'd0) begin
                        state_d  = DONE;
                        complete = 1'b1;
                    end else begin
                        state_d = WAITING;
                        cnt_d   = WAIT_C - 4'd1;
                    end
                end
            end
            WAITING: begin
                if (!REQ) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d  = DONE;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ack_d   = complete;
        oe_d    = complete & ~cur_we;
        rdata_d = '0;
        if (oe_d) begin
            rdata_d = mem_q[cur_addr];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            oe_q    <= oe_d;
            if (latch) begin
                we_q    <= WE;
                addr_q  <= ADDR;
                be_q    <= BE;
                wdata_q <= WDATA;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (complete && cur_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (cur_be[b]) begin
                    mem_q[cur_addr][8*b +: 8] <= cur_wdata[8*b +: 8];
                end
            end
        end
    end

    assign RDATA   = rdata_q;
    assign ACK     = ack_q;
    assign BUS_OE  = oe_q;
    assign nBUS_OE = ~oe_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: a WAIT=2 instance and a WAIT=0
// instance, each checked against a word-array reference memory.
module tb_mem_bus_responder;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;
    localparam int WT    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          nrst;

    logic          req, we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata, rdata;
    logic          ack, oe, noe;

    logic          req0, we0;
    logic [AW-1:0] addr0;
    logic [3:0]    be0;
    logic [31:0]   wdata0, rdata0;
    logic          ack0, oe0, noe0;

    mem_bus_responder #(.ADDR_W(AW), .WAIT(WT)) dut (
        .CLK(clk), .nRST(nrst), .REQ(req), .WE(we), .ADDR(addr), .BE(be),
        .WDATA(wdata), .RDATA(rdata), .ACK(ack), .BUS_OE(oe), .nBUS_OE(noe)
    );

    mem_bus_responder #(.ADDR_W(AW), .WAIT(0)) dut0 (
        .CLK(clk), .nRST(nrst), .REQ(req0), .WE(we0), .ADDR(addr0), .BE(be0),
        .WDATA(wdata0), .RDATA(rdata0), .ACK(ack0), .BUS_OE(oe0), .nBUS_OE(noe0)
    );

    logic [31:0] model  [DEPTH];
    logic [31:0] model0 [DEPTH];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] b);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) m = m | (32'hFF << (8 * i));
        end
        return (old & ~m) | (wd & m);
    endfunction

    task automatic clear_models();
        for (int i = 0; i < DEPTH; i++) begin
            model[i]  = 32'h0;
            model0[i] = 32'h0;
        end
    endtask

    // One transaction on the WAIT=2 instance: two dead cycles, then ACK.
    task automatic txn(input logic w, input logic [AW-1:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] got);
        int edges;
        logic [31:0] exp;
        exp = model[a];
        got = 32'h0;
        we = w; addr = a; be = b; wdata = d; req = 1'b1;
        edges = 0;
        while (1) begin
            @(posedge clk); #1;
            edges++;
            if (ack === 1'b1) break;
            checks++;
            if (oe !== 1'b0) begin
                errors++;
                $display("FAIL oe_before_ack got %b want 0 (edge %0d)", oe, edges);
            end
            if (edges > 30) begin
                errors++;
                $display("FAIL ack_timeout got no ACK want ACK after %0d edges", WT + 1);
                req = 1'b0;
                return;
            end
        end
        req = 1'b0;
        got = rdata;
        checks++;
        if (edges !== WT + 1) begin
            errors++;
            $display("FAIL ack_latency got %0d edges want %0d", edges, WT + 1);
        end
        checks++;
        if (oe !== !w) begin
            errors++;
            $display("FAIL oe_in_ack got %b want %b", oe, !w);
        end
        checks++;
        if (noe !== w) begin
            errors++;
            $display("FAIL noe_in_ack got %b want %b", noe, w);
        end
        if (!w) begin
            checks++;
            if (rdata !== exp) begin
                errors++;
                $display("FAIL read_data addr %0d got %h want %h", a, rdata, exp);
            end
        end else begin
            model[a] = merge(model[a], d, b);
        end
        @(posedge clk); #1;
        checks++;
        if ({ack, oe, noe, rdata} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL post_ack ack/oe/noe/rdata got %b%b%b %h want 001 00000000",
                     ack, oe, noe, rdata);
        end
    endtask

    // One transaction on the WAIT=0 instance: ACK right after acceptance.
    task automatic txn0(input logic w, input logic [AW-1:0] a, input logic [3:0] b,
                        input logic [31:0] d);
        logic [31:0] exp;
        exp = model0[a];
        we0 = w; addr0 = a; be0 = b; wdata0 = d; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        checks++;
        if ({ack0, oe0, noe0} !== {1'b1, !w, w}) begin
            errors++;
            $display("FAIL w0_ack ack/oe/noe got %b%b%b want 1%b%b", ack0, oe0, noe0, !w, w);
        end
        if (!w) begin
            checks++;
            if (rdata0 !== exp) begin
                errors++;
                $display("FAIL w0_read addr %0d got %h want %h", a, rdata0, exp);
            end
        end else begin
            model0[a] = merge(model0[a], d, b);
        end
        @(posedge clk); #1;
        checks++;
        if ({ack0, oe0, rdata0} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL w0_post_ack ack/oe/rdata got %b%b %h want 00 00000000",
                     ack0, oe0, rdata0);
        end
    endtask

    // Start a write and withdraw REQ after 'waits' wait cycles.
    task automatic abort_txn(input logic [AW-1:0] a, input logic [31:0] d, input int waits);
        we = 1'b1; addr = a; be = 4'hF; wdata = d; req = 1'b1;
        for (int i = 0; i <= waits + 1; i++) begin
            if (i == waits + 1) req = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL abort_ack addr %0d got %b want 0 (step %0d)", a, ack, i);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ack, oe, noe, rdata} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_out got %b%b%b %h want 001 00000000", ack, oe, noe, rdata);
        end
        checks++;
        if ({ack0, oe0, noe0, rdata0} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_out0 got %b%b%b %h want 001 00000000",
                     ack0, oe0, noe0, rdata0);
        end
        nrst = 1'b1;
        clear_models();
        for (int i = 0; i < DEPTH; i++) begin
            txn(1'b0, AW'(i), 4'h0, 32'h0, got);
            checks++;
            if (got !== 32'h0) begin
                errors++;
                $display("FAIL reset_mem addr %0d got %h want 00000000", i, got);
            end
        end
    endtask

    task automatic test_full_word();
        logic [31:0] got;
        txn(1'b1, AW'(5), 4'b1111, 32'hDEADBEEF, got);
        txn(1'b0, AW'(5), 4'b0000, 32'h0, got);
        checks++;
        if (got !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL full_word got %h want DEADBEEF", got);
        end
    endtask

    task automatic test_byte_mask();
        logic [31:0] got;
        txn(1'b1, AW'(5), 4'b0101, 32'h11223344, got);
        txn(1'b0, AW'(5), 4'b0000, 32'h0, got);
        checks++;
        if (got !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL byte_mask got %h want DE22BE44", got);
        end
        txn(1'b1, AW'(5), 4'b0000, 32'hFFFFFFFF, got);
        txn(1'b0, AW'(5), 4'b0000, 32'h0, got);
        checks++;
        if (got !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL be_zero got %h want DE22BE44", got);
        end
    endtask

    task automatic test_abort();
        logic [31:0] got;
        abort_txn(AW'(7), 32'hCAFEF00D, 1);
        txn(1'b0, AW'(7), 4'b0000, 32'h0, got);
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL abort_mem got %h want 00000000", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        for (int n = 0; n < 60; n++) begin
            int op;
            logic [AW-1:0] a;
            op = $urandom_range(0, 9);
            a  = AW'($urandom_range(0, DEPTH - 1));
            if (op == 0)      abort_txn(a, $urandom(), $urandom_range(0, WT - 1));
            else if (op < 5)  txn(1'b1, a, 4'($urandom_range(0, 15)), $urandom(), got);
            else              txn(1'b0, a, 4'($urandom_range(0, 15)), 32'h0, got);
        end
    endtask

    task automatic test_back_to_back();
        // WAIT=0 instance: ACK every 2 cycles while REQ stays high.
        txn0(1'b1, AW'(0), 4'hF, 32'h000000A0);
        txn0(1'b1, AW'(1), 4'hF, 32'h000000A1);
        txn0(1'b1, AW'(2), 4'hF, 32'h000000A2);
        we0 = 1'b0; be0 = 4'h0; addr0 = AW'(0); req0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ack0 !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL b2b0_ack cycle %0d got %b want %b", i, ack0, (i % 2 == 0));
            end
            if (i % 2 == 0) begin
                checks++;
                if (rdata0 !== 32'hA0 + 32'(i / 2) || oe0 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b0_data cycle %0d got %h oe %b want %h oe 1",
                             i, rdata0, oe0, 32'hA0 + 32'(i / 2));
                end
                addr0 = AW'(i / 2 + 1);
            end
        end
        req0 = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 20; n++) begin
            txn0($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)), $urandom());
        end
        // WAIT=2 instance: one completion every 4 cycles.
        we = 1'b0; be = 4'h0; addr = AW'(5); req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ack !== (i % 4 == 2)) begin
                errors++;
                $display("FAIL b2b2_ack cycle %0d got %b want %b", i, ack, (i % 4 == 2));
            end
            if (i % 4 == 2) begin
                checks++;
                if (rdata !== model[5]) begin
                    errors++;
                    $display("FAIL b2b2_data cycle %0d got %h want %h", i, rdata, model[5]);
                end
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        int guard;
        txn(1'b1, AW'(9), 4'hF, 32'h5A5AA5A5, got);
        we = 1'b0; be = 4'h0; addr = AW'(9); req = 1'b1;
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (ack !== 1'b1 && guard < 30);
        checks++;
        if (ack !== 1'b1 || rdata !== 32'h5A5AA5A5) begin
            errors++;
            $display("FAIL mid_pre_ack ack %b rdata %h want 1 5A5AA5A5", ack, rdata);
        end
        nrst = 1'b0;
        #1;
        checks++;
        if ({ack, oe, noe, rdata} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL mid_async got %b%b%b %h want 001 00000000", ack, oe, noe, rdata);
        end
        req = 1'b0;
        #1;
        nrst = 1'b1;
        clear_models();
        txn(1'b0, AW'(9), 4'h0, 32'h0, got);
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL mid_mem_clear got %h want 00000000", got);
        end
        txn(1'b1, AW'(9), 4'b1100, 32'h12345678, got);
        txn(1'b0, AW'(9), 4'h0, 32'h0, got);
        checks++;
        if (got !== 32'h12340000) begin
            errors++;
            $display("FAIL mid_after got %h want 12340000", got);
        end
        txn0(1'b0, AW'(1), 4'h0, 32'h0);
    endtask

    initial begin
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
        nrst = 1'b0;
        clear_models();
        test_reset();
        test_full_word();
        test_byte_mask();
        test_abort();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1);
    end

endmodule
